serial_word_feeder: RTL and testbench

//  Parallel-to-serial feeder for the x input of the serial pattern-detector FSM.
//  It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first, one bit per clk.

---
 rtl/serial_word_feeder.sv | 118 +++++++++++
 tb/tb_serial_word_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words over valid/ready and shifts
// each one out MSB-first, holding IDLE_LEVEL on ser_out between words.
module serial_word_feeder #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             last_bit;
  logic             accept;

  // With no gap, the next word may be taken while the last bit is on the wire.
  assign last_bit = (state == SHIFT) && (bit_cnt == '0);
  assign in_ready = !rst && enable &&
                    ((state == IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign accept   = in_valid && in_ready;

  // Outputs are registered alongside the state so they never depend on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            shreg     <= in_data;
            bit_cnt   <= LAST_IDX;
            ser_out   <= in_data[WIDTH-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            word_done <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            shreg     <= shreg << 1;
            bit_cnt   <= bit_cnt - CW'(1);
            ser_out   <= shreg[WIDTH-2];
            word_done <= (bit_cnt == CW'(1));
          end else if (accept) begin
            shreg     <= in_data;
            bit_cnt   <= LAST_IDX;
            ser_out   <= in_data[WIDTH-1];
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            word_done <= 1'b0;
          end else if (GAP_CYCLES > 0) begin
            state     <= GAP;
            gap_cnt   <= GAP_LOAD;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            busy      <= 1'b1;
            word_done <= 1'b0;
          end else begin
            state     <= IDLE;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= IDLE;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          ser_out   <= IDLE_LEVEL;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder: a default instance (GAP_CYCLES=2)
// checked against a queue-based schedule model, plus a GAP_CYCLES=0 instance.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_en, a_valid, a_ready, a_ser, a_sval, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_en, b_valid, b_ready, b_ser, b_sval, b_busy, b_done;
  logic [7:0] b_data;

  int checks = 0;
  int passed = 0;

  serial_word_feeder #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) u_a (
    .clk(clk), .rst(rst), .enable(a_en), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .ser_out(a_ser), .ser_valid(a_sval), .busy(a_busy),
    .word_done(a_done)
  );

  serial_word_feeder #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst(rst), .enable(b_en), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .ser_out(b_ser), .ser_valid(b_sval), .busy(b_busy),
    .word_done(b_done)
  );

  always #5 clk = ~clk;

  // Model: each accepted word schedules its future output cycles in a queue.
  typedef struct packed {
    logic ser;
    logic sval;
    logic busy;
    logic done;
  } slot_t;

  slot_t       sched[$];
  logic [15:0] stream;
  int          bit_count;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic model_ready();
    return a_en && !rst && (sched.size() == 0);
  endfunction

  function automatic logic [4:0] model_expect();
    logic r;
    r = model_ready();
    if (sched.size() == 0) return {r, 1'b1, 3'b000};
    return {r, sched[0].ser, sched[0].sval, sched[0].busy, sched[0].done};
  endfunction

  function automatic void push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) sched.push_back('{w[i], 1'b1, 1'b1, (i == 0)});
    for (int g = 0; g < 2; g++) sched.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
  endfunction

  task automatic check_output(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic apply_stimulus(input logic en, input logic valid, input logic [7:0] data);
    a_en    = en;
    a_valid = valid;
    a_data  = data;
  endtask

  // One cycle of instance A against the model; inputs must already be driven.
  task automatic model_cycle(input string name);
    logic       acc;
    logic [7:0] d;
    @(negedge clk);
    check_output(name, {a_ready, a_ser, a_sval, a_busy, a_done}, model_expect());
    if (a_sval) begin
      stream = {stream[14:0], a_ser};
      bit_count++;
    end
    acc = model_ready() && a_valid;
    d   = a_data;
    @(posedge clk);
    if (sched.size() != 0) void'(sched.pop_front());
    if (acc) push_word(d);
    #1;
  endtask

  initial begin
    logic [15:0] bstream;
    logic [17:0] bdone;
    int          bcount;

    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    b_en = 1'b1; b_valid = 1'b0; b_data = 8'h00;

    // Reset held with enable high.
    @(negedge clk);
    check_output("reset_a", {a_ready, a_ser, a_sval, a_busy, a_done}, 5'b0_1000);
    check_output("reset_b", {b_ready, b_ser, b_sval, b_busy, b_done}, 5'b0_1000);
    @(posedge clk); #1;
    rst = 1'b0;
    model_cycle("rst_release_ready");

    // Single word 0100_1101: bits, gap, ready again in cycle 11.
    vecs[0] = '{1'b1, 1'b1, 8'h4D, 5'b1_1000};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 5'b0_0110};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 5'b0_1110};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 5'b0_0110};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 5'b0_0110};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 5'b0_1110};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 5'b0_1110};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 5'b0_0110};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 5'b0_1111};
    vecs[9] = '{1'b1, 1'b0, 8'h00, 5'b0_1010};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 5'b0_1010};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 5'b1_1000};
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].en, vecs[i].valid, vecs[i].data);
      @(negedge clk);
      check_output($sformatf("single_word_c%0d", i),
                   {a_ready, a_ser, a_sval, a_busy, a_done}, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Back-to-back words on the no-gap instance.
    b_valid = 1'b1; b_data = 8'hA5;
    bstream = '0; bdone = '0; bcount = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) check_output("gap0_ready_first", b_ready, 1'b1);
      if (i == 8) check_output("gap0_ready_last_bit", b_ready, 1'b1);
      if (b_sval) begin
        bstream = {bstream[14:0], b_ser};
        bcount++;
      end
      if (b_done) bdone[i] = 1'b1;
      if (i == 17) check_output("gap0_idle_after", {b_ready, b_sval, b_busy}, 3'b100);
      @(posedge clk); #1;
      if (i == 0) b_data = 8'hA5 ^ 8'h99;
      if (i == 8) b_valid = 1'b0;
    end
    check_output("gap0_stream", bstream, 16'hA53C);
    check_output("gap0_bit_count", bcount, 16);
    check_output("gap0_word_done", bdone, 18'h10100);

    // in_valid held with FF while 00 shifts: no early accept.
    stream = '0; bit_count = 0;
    apply_stimulus(1'b1, 1'b1, 8'h00);
    model_cycle("hold_accept0");
    a_data = 8'hFF;
    for (int i = 1; i < 12; i++) model_cycle($sformatf("hold_c%0d", i));
    a_valid = 1'b0;
    for (int i = 12; i < 22; i++) model_cycle($sformatf("hold_c%0d", i));
    check_output("hold_stream", stream, 16'h00FF);
    check_output("hold_bit_count", bit_count, 16);

    // enable low blocks acceptance; dropping it mid-word does not stall.
    apply_stimulus(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) model_cycle($sformatf("en_low_c%0d", i));
    stream = '0; bit_count = 0;
    a_en = 1'b1;
    model_cycle("en_accept");
    a_valid = 1'b0;
    model_cycle("en_bit1");
    model_cycle("en_bit2");
    a_en = 1'b0;
    for (int i = 3; i < 14; i++) model_cycle($sformatf("en_drop_c%0d", i));
    check_output("en_drop_bits", bit_count, 8);
    check_output("en_drop_stream", stream[7:0], 8'hC3);

    // Async reset during the 4th bit of F0 discards the word.
    apply_stimulus(1'b1, 1'b1, 8'hF0);
    model_cycle("rst_mid_accept");
    a_valid = 1'b0;
    for (int i = 1; i < 4; i++) model_cycle($sformatf("rst_mid_bit%0d", i));
    @(negedge clk);
    check_output("rst_mid_bit4", {a_ready, a_ser, a_sval, a_busy, a_done}, model_expect());
    rst = 1'b1;
    #1;
    check_output("rst_mid_immediate", {a_ready, a_ser, a_sval, a_busy, a_done}, 5'b0_1000);
    sched.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    stream = '0; bit_count = 0;
    for (int i = 0; i < 10; i++) model_cycle($sformatf("rst_after_c%0d", i));
    check_output("rst_not_resumed", bit_count, 0);

    // Randomised traffic against the schedule model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom));
      model_cycle($sformatf("rand_c%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
